// File: rtl/game_pkg.sv
// Shared definitions for the snake-game rabbit spawner.
// Holds the LED bus width, the spawner state encoding, the LFSR taps and
// the PICK retry limit, plus small combinational helpers used by the
// spawner and its LFSR.
package game_pkg;

    localparam int LED_W = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PICK     = 2'd1,
        ACTIVE   = 2'd2,
        COOLDOWN = 2'd3
    } state_t;

    localparam logic [7:0] LFSR_TAPS = 8'hB8;
    localparam logic [3:0] MAX_TRIES = 4'd8;

    // One step of the right-shifting Galois LFSR.
    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return (l >> 1) ^ (l[0] ? LFSR_TAPS : 8'h00);
    endfunction

    // Candidate rabbit position: one-hot of the low three LFSR bits.
    function automatic logic [LED_W-1:0] cand_of(input logic [7:0] l);
        return {{(LED_W-1){1'b0}}, 1'b1} << l[2:0];
    endfunction

    // Lowest-index LED not occupied by the snake (all-zero when full).
    // free & -free isolates the lowest set bit of the free mask.
    function automatic logic [LED_W-1:0] lowest_free(input logic [LED_W-1:0] snake);
        logic [LED_W-1:0] free;
        free = ~snake;
        return free & (~free + {{(LED_W-1){1'b0}}, 1'b1});
    endfunction

endpackage

// File: rtl/rabbit_spawner_lfsr8.sv
// 8-bit Galois LFSR used to pick rabbit positions.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset, loads seed (0 replaced by 8'h01)
//   adv  - advance one step this cycle
//   seed - reset value
//   q    - current LFSR state
// An all-zero state would lock the LFSR, so it is reloaded with 8'h01.
module lfsr8
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       adv,
    input  logic [7:0] seed,
    output logic [7:0] q
);

    // LFSR state register with seed load and zero-lock recovery.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= (seed == 8'h00) ? 8'h01 : seed;
        end else if (q == 8'h00) begin
            q <= 8'h01;
        end else if (adv) begin
            q <= lfsr_next(q);
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/rabbit_spawner.sv
// Rabbit spawner: producer side of the snake-game "eat" interface.
// Places a one-hot rabbit that never overlaps the snake, acknowledges the
// rising edge of eat_pulse, waits RESPAWN_DLY cycles, then respawns.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   enable        - game running; low forces IDLE and clears the rabbit
//   snake_led     - one-hot snake position (0 = none)
//   eat_pulse     - score detector level, high while snake == rabbit
//   rabbit_led    - one-hot rabbit position, 0 when no rabbit
//   rabbit_valid  - rabbit_led holds a live rabbit
//   eat_ack       - one-cycle pulse per accepted eat
//   spawn_count   - spawns since reset, wraps 255 -> 0
// Optional macro RABBIT_BLINK_EN: blinks rabbit_led from a free-running
// 24-bit counter; all internal decisions keep using the steady rabbit_reg.
module rabbit_spawner
    import game_pkg::*;
#(
    parameter int         LED_W       = game_pkg::LED_W,
    parameter int         RESPAWN_DLY = 16,
    parameter logic [7:0] LFSR_SEED   = 8'hA5
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [LED_W-1:0] snake_led,
    input  logic             eat_pulse,
    output logic [LED_W-1:0] rabbit_led,
    output logic             rabbit_valid,
    output logic             eat_ack,
    output logic [7:0]       spawn_count
);

    localparam int CD_W = (RESPAWN_DLY > 1) ? $clog2(RESPAWN_DLY) : 1;
    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(RESPAWN_DLY - 1);

    state_t           state, state_next;
    logic [LED_W-1:0] rabbit_reg, rabbit_next;
    logic             valid_next, ack_next;
    logic [7:0]       count_next;
    logic [CD_W-1:0]  cooldown, cd_next;
    logic [3:0]       tries, tries_next;
    logic             eat_d, eat_ev;
    logic             lfsr_adv;
    logic [7:0]       lfsr_q;
    logic [LED_W-1:0] cand, fallback;

    lfsr8 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .adv  (lfsr_adv),
        .seed (LFSR_SEED),
        .q    (lfsr_q)
    );

    assign eat_ev   = eat_pulse & ~eat_d;
    assign cand     = cand_of(lfsr_q);
    assign fallback = lowest_free(snake_led);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and next-output logic; enable=0 overrides everything but reset.
    always_comb begin
        state_next  = state;
        rabbit_next = rabbit_reg;
        valid_next  = rabbit_valid;
        ack_next    = 1'b0;
        count_next  = spawn_count;
        cd_next     = cooldown;
        tries_next  = 4'd0;
        lfsr_adv    = 1'b0;
        if (!enable) begin
            state_next  = IDLE;
            rabbit_next = {LED_W{1'b0}};
            valid_next  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state_next = PICK;
                end
                PICK: begin
                    lfsr_adv = 1'b1;
                    if (tries >= MAX_TRIES) begin
                        // Random tries exhausted: deterministic scan, unless the snake fills the bar.
                        if (fallback != {LED_W{1'b0}}) begin
                            rabbit_next = fallback;
                            valid_next  = 1'b1;
                            count_next  = spawn_count + 8'd1;
                            state_next  = ACTIVE;
                        end else begin
                            tries_next = tries;
                        end
                    end else if ((cand & snake_led) == {LED_W{1'b0}}) begin
                        rabbit_next = cand;
                        valid_next  = 1'b1;
                        count_next  = spawn_count + 8'd1;
                        state_next  = ACTIVE;
                    end else begin
                        tries_next = tries + 4'd1;
                    end
                end
                ACTIVE: begin
                    if (eat_ev) begin
                        rabbit_next = {LED_W{1'b0}};
                        valid_next  = 1'b0;
                        ack_next    = 1'b1;
                        cd_next     = CD_LOAD;
                        state_next  = COOLDOWN;
                    end else begin
                        state_next = ACTIVE;
                    end
                end
                COOLDOWN: begin
                    if (cooldown == {CD_W{1'b0}}) begin
                        state_next = PICK;
                    end else begin
                        cd_next = cooldown - CD_W'(1);
                    end
                end
                default: begin
                    state_next  = IDLE;
                    rabbit_next = {LED_W{1'b0}};
                    valid_next  = 1'b0;
                end
            endcase
        end
    end

    // Datapath registers and eat edge-detect history.
    always_ff @(posedge clk) begin
        if (rst) begin
            rabbit_reg   <= {LED_W{1'b0}};
            rabbit_valid <= 1'b0;
            eat_ack      <= 1'b0;
            spawn_count  <= 8'd0;
            cooldown     <= {CD_W{1'b0}};
            tries        <= 4'd0;
            eat_d        <= 1'b0;
        end else begin
            rabbit_reg   <= rabbit_next;
            rabbit_valid <= valid_next;
            eat_ack      <= ack_next;
            spawn_count  <= count_next;
            cooldown     <= cd_next;
            tries        <= tries_next;
            eat_d        <= eat_pulse;
        end
    end

`ifdef RABBIT_BLINK_EN
    logic [23:0] blink_cnt;

    // Free-running blink divider.
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt <= 24'd0;
        end else begin
            blink_cnt <= blink_cnt + 24'd1;
        end
    end

    assign rabbit_led = rabbit_reg & {LED_W{blink_cnt[23]}};
`else
    assign rabbit_led = rabbit_reg;
`endif

endmodule

// File: tb/tb_rabbit_spawner.sv
// Directed self-checking bench for rabbit_spawner (default parameters).
module tb_rabbit_spawner;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [7:0] snake_led;
    logic       eat_pulse;
    logic [7:0] rabbit_led;
    logic       rabbit_valid;
    logic       eat_ack;
    logic [7:0] spawn_count;

    int checks = 0;
    int errors = 0;

    localparam int DLY = 16;

    rabbit_spawner dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .snake_led    (snake_led),
        .eat_pulse    (eat_pulse),
        .rabbit_led   (rabbit_led),
        .rabbit_valid (rabbit_valid),
        .eat_ack      (eat_ack),
        .spawn_count  (spawn_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; snake_led = 8'h00; eat_pulse = 1'b0;
        tick(); tick();
        chk("rst_led", rabbit_led, 8'h00);
        chk("rst_valid", {7'd0, rabbit_valid}, 8'h00);
        chk("rst_ack", {7'd0, eat_ack}, 8'h00);
        chk("rst_count", spawn_count, 8'h00);

        // First spawn: seed A5 -> candidate bit 5.
        rst = 1'b0; enable = 1'b1;
        tick();
        chk("pick_not_yet_valid", {7'd0, rabbit_valid}, 8'h00);
        tick();
        chk("spawn1_led", rabbit_led, 8'h20);
        chk("spawn1_valid", {7'd0, rabbit_valid}, 8'h01);
        chk("spawn1_count", spawn_count, 8'h01);

        // eat held 5 cycles: one ack only.
        eat_pulse = 1'b1;
        tick();
        chk("eat_ack", {7'd0, eat_ack}, 8'h01);
        chk("eat_led_clr", rabbit_led, 8'h00);
        chk("eat_valid_clr", {7'd0, rabbit_valid}, 8'h00);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("eat_level_no_ack", {7'd0, eat_ack}, 8'h00);
        end
        eat_pulse = 1'b0;
        // Rabbit returns RESPAWN_DLY+1 cycles after the ack (4 already elapsed).
        for (int i = 0; i < DLY - 4; i++) tick();
        chk("cooldown_valid_low", {7'd0, rabbit_valid}, 8'h00);
        tick();
        chk("respawn_valid", {7'd0, rabbit_valid}, 8'h01);
        chk("respawn_led", rabbit_led, 8'h04);
        chk("respawn_count", spawn_count, 8'h02);

        // Eat edge together with enable=0: disable wins.
        eat_pulse = 1'b1; enable = 1'b0;
        tick();
        chk("dis_no_ack", {7'd0, eat_ack}, 8'h00);
        chk("dis_led", rabbit_led, 8'h00);
        chk("dis_valid", {7'd0, rabbit_valid}, 8'h00);
        chk("dis_count_kept", spawn_count, 8'h02);
        eat_pulse = 1'b0; enable = 1'b1;
        tick(); tick();
        chk("reen_led", rabbit_led, 8'h20);
        chk("reen_count", spawn_count, 8'h03);

        // Full snake: no spawn; then one free LED found by fallback scan.
        eat_pulse = 1'b1;
        tick();
        chk("eat2_ack", {7'd0, eat_ack}, 8'h01);
        eat_pulse = 1'b0; snake_led = 8'hFF;
        for (int i = 0; i < DLY + 20; i++) tick();
        chk("full_no_valid", {7'd0, rabbit_valid}, 8'h00);
        chk("full_count", spawn_count, 8'h03);
        snake_led = 8'h7F;
        tick();
        chk("fallback_led", rabbit_led, 8'h80);
        chk("fallback_count", spawn_count, 8'h04);

        // Collision on first candidate after reset.
        rst = 1'b1; tick();
        rst = 1'b0; snake_led = 8'h20; enable = 1'b1;
        tick();
        tick();
        chk("collide_no_valid", {7'd0, rabbit_valid}, 8'h00);
        tick();
        chk("collide_led", rabbit_led, 8'h04);
        chk("collide_count", spawn_count, 8'h01);

        // 255 more spawns via enable toggling: count wraps to 0.
        snake_led = 8'h00;
        for (int i = 0; i < 255; i++) begin
            enable = 1'b0; tick();
            enable = 1'b1; tick(); tick();
            if (i == 253) chk("count_255", spawn_count, 8'hFF);
        end
        chk("wrap_count", spawn_count, 8'h00);
        chk("wrap_valid", {7'd0, rabbit_valid}, 8'h01);

        // Reset in the middle of cooldown.
        eat_pulse = 1'b1;
        tick();
        chk("eat3_ack", {7'd0, eat_ack}, 8'h01);
        eat_pulse = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        chk("midrst_led", rabbit_led, 8'h00);
        chk("midrst_valid", {7'd0, rabbit_valid}, 8'h00);
        chk("midrst_ack", {7'd0, eat_ack}, 8'h00);
        chk("midrst_count", spawn_count, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rabbit_spawner.md
Name: rabbit_spawner

Overview:
- Producer side of the snake-game "eat" interface.
- Places the rabbit as a one-hot LED position that never overlaps the snake.
- Consumes the eat pulse from the score detector, clears the rabbit, waits a cooldown, then respawns at a pseudo-random free LED.
- Drives the rabbit position bus that the score detector compares against the snake position.

Parameters:
- LED_W, 8, LED count; rabbit/snake bus width (fixed 8 in this revision; index = 3 bits).
- RESPAWN_DLY, 16, clk cycles between eat and next PICK (min 1).
- LFSR_SEED, 8'hA5, LFSR reset value (0 is illegal; replaced by 8'h01).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  game running; low forces IDLE.
- snake_led  in  LED_W  current snake one-hot position (0 = none).
- eat_pulse  in  1  score-detector clear level, high while snake == rabbit.
- rabbit_led  out  LED_W  one-hot rabbit position, 0 when no rabbit.
- rabbit_valid  out  1  rabbit_led holds a live rabbit.
- eat_ack  out  1  single-cycle pulse per accepted eat.
- spawn_count  out  8  number of spawns since reset, wraps 255->0.

Behaviour:
- Reset (rst=1 at edge):
  - state=IDLE, rabbit_led=0, rabbit_valid=0, eat_ack=0, spawn_count=0.
  - lfsr=LFSR_SEED, eat_d=0, cooldown=0.
- LFSR:
  - 8-bit Galois, right shift, taps 8'hB8: next = (l>>1) ^ (l[0] ? 8'hB8 : 0).
  - Advances only in PICK, once per cycle.
  - If it ever reads 0, reload 8'h01.
- Eat event: eat_ev = eat_pulse & ~eat_d. eat_d is registered every cycle in all states.
- Candidate: cand = 1 << lfsr[2:0].
- States:
  - IDLE: rabbit outputs 0. enable=1 -> PICK.
  - PICK:
    - If (cand & snake_led)==0: rabbit_led<=cand, rabbit_valid<=1, spawn_count++, -> ACTIVE.
    - Otherwise retry next cycle; tries counter +1.
    - After 8 failed tries: take the lowest-index free bit of ~snake_led.
    - If snake_led==8'hFF: stay PICK, no spawn.
    - tries clears on entering PICK.
  - ACTIVE:
    - eat_ev=1: rabbit_led<=0, rabbit_valid<=0, eat_ack<=1 for one cycle, cooldown<=RESPAWN_DLY-1, -> COOLDOWN.
    - Level eat_pulse without an edge is ignored.
  - COOLDOWN: cooldown decrements; at 0 -> PICK.
- Priority:
  - rst > enable=0 > eat_ev.
  - enable=0 in any state: next cycle IDLE, rabbit_led=0, rabbit_valid=0, eat_ack=0; spawn_count and lfsr retained.
- eat_ev outside ACTIVE is ignored (no ack).
- Latency:
  - enable rise sampled at edge N gives PICK at N+1.
  - Earliest rabbit_valid is at N+2.
  - eat edge sampled at edge M gives rabbit_led=0 and eat_ack=1 at M+1.
  - Next PICK at M+1+RESPAWN_DLY.
- All outputs registered; no combinational input->output path.

Optional Feature:
- Macro: RABBIT_BLINK_EN.
- When defined: a free-running 24-bit counter gates the rabbit output, rabbit_led = rabbit_reg & {LED_W{blink_cnt[23]}}. rabbit_valid, eat logic and the PICK collision check use the ungated rabbit_reg.
- When undefined: rabbit_led = rabbit_reg, steady; the counter is absent.

Decomposition:
- Shared package (game_pkg): LED_W, state encodings (IDLE=0, PICK=1, ACTIVE=2, COOLDOWN=3), LFSR taps 8'hB8, max PICK tries = 8.
- One sub-module: lfsr8 (ports: clk, rst, adv, seed -> q), which includes zero-lock recovery.

Test Plan:
- Reset then enable=1, snake_led=0: rabbit_led=8'h20, rabbit_valid=1 two cycles after enable; spawn_count=1.
- Reset, snake_led=8'h20, enable=1: first candidate collides; LFSR 8'hA5->8'hEA gives rabbit_led=8'h04 one cycle later.
- ACTIVE, eat_pulse held high 5 cycles: exactly one eat_ack pulse; rabbit_led=0; rabbit_valid returns exactly RESPAWN_DLY+1 cycles after ack.
- snake_led=8'hFF in PICK for 20 cycles: no spawn, spawn_count unchanged. snake_led->8'h7F: rabbit_led=8'h80 within 1 cycle (fallback scan).
- eat edge and enable=0 in the same cycle: no eat_ack, IDLE next cycle, rabbit_led=0. Re-enable: new spawn, spawn_count increments.
- 256 spawns: spawn_count wraps to 0; rst mid-COOLDOWN: all outputs 0 the next cycle.
